se_sweep: RTL and testbench

SE_SWEEP -- requirements
Module: se_sweep

---
 rtl/se_sweep_if.sv | 39 +++
 rtl/se_sweep.sv | 120 ++++++++++++
 tb/tb_se_sweep.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/se_sweep_if.sv
// se_sweep_if: control/status bundle between a sweep controller and its driver
// Signals: iTrig/iStop commands; iStartFreq/iStep/iDir/iNotes/iDuration sweep
// setup (latched on trigger); iRepeat extra passes when SE_SWEEP_REPEAT_EN is
// defined; oEnable/oFreq tone output; oBusy sequence active; oDone completion pulse.
// Modports: master drives commands and reads status, slave is the sweep block.
interface se_sweep_if #(
  parameter int FREQ_W = 16,
  parameter int DUR_W  = 32,
  parameter int CNT_W  = 8
) ();
  logic              iTrig;
  logic              iStop;
  logic [FREQ_W-1:0] iStartFreq;
  logic [FREQ_W-1:0] iStep;
  logic              iDir;
  logic [CNT_W-1:0]  iNotes;
  logic [DUR_W-1:0]  iDuration;
`ifdef SE_SWEEP_REPEAT_EN
  logic [3:0]        iRepeat;
`endif
  logic              oEnable;
  logic [FREQ_W-1:0] oFreq;
  logic              oBusy;
  logic              oDone;
  modport master (
    output iTrig, iStop, iStartFreq, iStep, iDir, iNotes, iDuration,
`ifdef SE_SWEEP_REPEAT_EN
    output iRepeat,
`endif
    input  oEnable, oFreq, oBusy, oDone
  );
  modport slave (
    input  iTrig, iStop, iStartFreq, iStep, iDir, iNotes, iDuration,
`ifdef SE_SWEEP_REPEAT_EN
    input  iRepeat,
`endif
    output oEnable, oFreq, oBusy, oDone
  );
endinterface

// File: rtl/se_sweep.sv
// se_sweep: frequency sweep sequencer playing a run of saturating up/down notes
// Ports: iClock clock; iReset async active-high reset; bus (se_sweep_if.slave)
// carries trigger/stop, latched sweep setup and the tone/busy/done outputs.
// Option: define SE_SWEEP_REPEAT_EN to add bus.iRepeat (extra passes, 15 = loop).
module se_sweep #(
  parameter int FREQ_W     = 16,
  parameter int DUR_W      = 32,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 0
) (
  input logic     iClock,
  input logic     iReset,
  se_sweep_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_t            state, state_n;
  logic [FREQ_W-1:0] freq, freq_n, start_l, start_n, step_l, step_n;
  logic              dir_l, dir_n, done, done_n;
  logic [CNT_W-1:0]  notes_l, notes_n, ncnt, ncnt_n;
  logic [DUR_W-1:0]  dlast, dlast_n, dcnt, dcnt_n;
  logic [GW-1:0]     gcnt, gcnt_n;
  logic [3:0]        rep, rep_n, rep_in;
`ifdef SE_SWEEP_REPEAT_EN
  assign rep_in = bus.iRepeat;
`else
  assign rep_in = 4'd0;
`endif
  function automatic logic [FREQ_W-1:0] nxt(input logic [FREQ_W-1:0] f, input logic [FREQ_W-1:0] s, input logic up);
    logic [FREQ_W:0] sum;
    sum = {1'b0, f} + {1'b0, s};
    return up ? (sum[FREQ_W] ? '1 : sum[FREQ_W-1:0]) : (f < s ? '0 : f - s);
  endfunction
  always_comb begin
    state_n = state;
    freq_n  = freq;
    start_n = start_l;
    step_n  = step_l;
    dir_n   = dir_l;
    notes_n = notes_l;
    dlast_n = dlast;
    rep_n   = rep;
    ncnt_n  = ncnt;
    dcnt_n  = dcnt;
    gcnt_n  = gcnt;
    done_n  = 1'b0;
    if (bus.iStop) begin
      state_n = IDLE;
    end else if (bus.iTrig && bus.iNotes != '0) begin
      state_n = PLAY;
      freq_n  = bus.iStartFreq;
      start_n = bus.iStartFreq;
      step_n  = bus.iStep;
      dir_n   = bus.iDir;
      notes_n = bus.iNotes;
      dlast_n = bus.iDuration == '0 ? '0 : bus.iDuration - DUR_W'(1);
      rep_n   = rep_in;
      ncnt_n  = '0;
      dcnt_n  = '0;
    end else if (state == PLAY) begin
      dcnt_n = dcnt + DUR_W'(1);
      if (dcnt == dlast) begin
        dcnt_n = '0;
        gcnt_n = '0;
        if (ncnt != notes_l - CNT_W'(1)) begin
          ncnt_n  = ncnt + CNT_W'(1);
          freq_n  = nxt(freq, step_l, dir_l);
          state_n = GAP_CYCLES > 0 ? GAP : PLAY;
        end else if (rep != 4'd0) begin
          // 15 never counts down, so the sequence loops until stopped
          rep_n   = rep == 4'd15 ? rep : rep - 4'd1;
          ncnt_n  = '0;
          freq_n  = start_l;
          state_n = GAP_CYCLES > 0 ? GAP : PLAY;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
    end else if (state == GAP) begin
      gcnt_n  = gcnt + GW'(1);
      state_n = gcnt == G_LAST ? PLAY : GAP;
    end
  end
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state   <= IDLE;
      freq    <= '0;
      start_l <= '0;
      step_l  <= '0;
      dir_l   <= 1'b0;
      notes_l <= '0;
      dlast   <= '0;
      rep     <= 4'd0;
      ncnt    <= '0;
      dcnt    <= '0;
      gcnt    <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      freq    <= freq_n;
      start_l <= start_n;
      step_l  <= step_n;
      dir_l   <= dir_n;
      notes_l <= notes_n;
      dlast   <= dlast_n;
      rep     <= rep_n;
      ncnt    <= ncnt_n;
      dcnt    <= dcnt_n;
      gcnt    <= gcnt_n;
      done    <= done_n;
    end
  end
  // outputs decode straight from state so async reset clears them at once
  assign bus.oEnable = state == PLAY;
  assign bus.oFreq   = state == PLAY ? freq : '0;
  assign bus.oBusy   = state != IDLE;
  assign bus.oDone   = done;
endmodule

// File: tb/tb_se_sweep.sv
// tb_se_sweep: scoreboard bench for se_sweep, one gapless and one gapped instance
module tb_se_sweep;
  localparam int FW = 8;
  localparam int DW = 8;
  localparam int CW = 8;
`ifdef SE_SWEEP_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  typedef struct packed {logic en; logic [FW-1:0] f; logic busy; logic done;} exp_t;
  typedef exp_t q_t[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0, stop = 1'b0, dir = 1'b0;
  logic [FW-1:0] sf = '0, st = '0;
  logic [CW-1:0] nt = '0;
  logic [DW-1:0] du = '0;
  logic [3:0] rep = '0;
  int tests = 0, fails = 0;
  q_t tl0, tl1, sb0, sb1;
  always #5 clk = ~clk;
  se_sweep_if #(.FREQ_W(FW), .DUR_W(DW), .CNT_W(CW)) b0 ();
  se_sweep_if #(.FREQ_W(FW), .DUR_W(DW), .CNT_W(CW)) b1 ();
  assign b0.iTrig = trig;      assign b1.iTrig = trig;
  assign b0.iStop = stop;      assign b1.iStop = stop;
  assign b0.iStartFreq = sf;   assign b1.iStartFreq = sf;
  assign b0.iStep = st;        assign b1.iStep = st;
  assign b0.iDir = dir;        assign b1.iDir = dir;
  assign b0.iNotes = nt;       assign b1.iNotes = nt;
  assign b0.iDuration = du;    assign b1.iDuration = du;
`ifdef SE_SWEEP_REPEAT_EN
  assign b0.iRepeat = rep;     assign b1.iRepeat = rep;
`endif
  se_sweep #(.FREQ_W(FW), .DUR_W(DW), .CNT_W(CW), .GAP_CYCLES(0)) u0 (.iClock(clk), .iReset(rst), .bus(b0.slave));
  se_sweep #(.FREQ_W(FW), .DUR_W(DW), .CNT_W(CW), .GAP_CYCLES(3)) u1 (.iClock(clk), .iReset(rst), .bus(b1.slave));
  function automatic exp_t mk(input logic e, input int f, input logic b, input logic d);
    return {e, FW'(f), b, d};
  endfunction
  // whole expected output timeline of one triggered sequence, cycle by cycle
  function automatic q_t build(input int gap, input int f0, input int stp, input bit up, input int n, input int dur, input int rp);
    q_t q;
    int d = dur == 0 ? 1 : dur;
    int eff = REP_EN ? rp : 0;
    int passes = eff == 15 ? 200 : eff + 1;
    int f;
    int mx = (1 << FW) - 1;
    for (int p = 0; p < passes; p++) begin
      f = f0;
      for (int k = 0; k < n; k++) begin
        if (p > 0 || k > 0)
          for (int g = 0; g < gap; g++) q.push_back(mk(1'b0, 0, 1'b1, 1'b0));
        for (int c = 0; c < d; c++) q.push_back(mk(1'b1, f, 1'b1, 1'b0));
        f = up ? (f + stp > mx ? mx : f + stp) : (f - stp < 0 ? 0 : f - stp);
      end
    end
    if (eff != 15) q.push_back(mk(1'b0, 0, 1'b0, 1'b1));
    return q;
  endfunction
  function automatic void chk(input string nm, input exp_t a, input exp_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s t=%0t got en=%b f=%0d busy=%b done=%b want en=%b f=%0d busy=%b done=%b",
               nm, $time, a.en, a.f, a.busy, a.done, e.en, e.f, e.busy, e.done);
    end
  endfunction
  always @(posedge clk) begin
    if (rst || stop) begin
      tl0.delete();
      tl1.delete();
    end else if (trig && nt != 0) begin
      tl0 = build(0, int'(sf), int'(st), dir, int'(nt), int'(du), int'(rep));
      tl1 = build(3, int'(sf), int'(st), dir, int'(nt), int'(du), int'(rep));
    end
    sb0.push_back(tl0.size() != 0 ? tl0.pop_front() : mk(1'b0, 0, 1'b0, 1'b0));
    sb1.push_back(tl1.size() != 0 ? tl1.pop_front() : mk(1'b0, 0, 1'b0, 1'b0));
  end
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb0.size() != 0) begin
      e = sb0.pop_front();
      chk("gap0", {b0.oEnable, b0.oFreq, b0.oBusy, b0.oDone}, e);
    end
    if (sb1.size() != 0) begin
      e = sb1.pop_front();
      chk("gap3", {b1.oEnable, b1.oFreq, b1.oBusy, b1.oDone}, e);
    end
  end
  task automatic drv(input bit t, input bit s, input int a, input int b, input bit d, input int n, input int u, input int r);
    @(negedge clk);
    trig = t; stop = s; sf = FW'(a); st = FW'(b); dir = d; nt = CW'(n); du = DW'(u); rep = 4'(r);
  endtask
  task automatic junk(input int n);
    repeat (n) drv(1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15));
  endtask
  function automatic int pick_start();
    if ($urandom_range(0, 3) != 0) return $urandom_range(0, 255);
    return $urandom_range(0, 1) != 0 ? $urandom_range(245, 255) : $urandom_range(0, 10);
  endfunction
  initial begin
    #1;
    chk("reset0", {b0.oEnable, b0.oFreq, b0.oBusy, b0.oDone}, mk(1'b0, 0, 1'b0, 1'b0));
    chk("reset1", {b1.oEnable, b1.oFreq, b1.oBusy, b1.oDone}, mk(1'b0, 0, 1'b0, 1'b0));
    junk(3);
    rst = 1'b0;
    drv(1'b1, 1'b0, 220, 10, 1'b0, 18, 4, 0);
    junk(90);
    drv(1'b1, 1'b0, 15, 10, 1'b0, 3, 2, 0);
    junk(14);
    drv(1'b1, 1'b0, 250, 10, 1'b1, 3, 2, 0);
    junk(14);
    drv(1'b1, 1'b0, 100, 5, 1'b1, 2, 2, 0);
    junk(12);
    drv(1'b1, 1'b0, 50, 1, 1'b1, 4, 0, 0);
    junk(3);
    drv(1'b1, 1'b0, 99, 9, 1'b0, 0, 3, 0);
    junk(20);
    drv(1'b1, 1'b0, 200, 10, 1'b0, 10, 2, 0);
    junk(9);
    drv(1'b1, 1'b0, 30, 3, 1'b1, 3, 2, 0);
    junk(20);
    drv(1'b1, 1'b0, 70, 7, 1'b1, 5, 3, 0);
    junk(3);
    drv(1'b1, 1'b1, 80, 8, 1'b1, 5, 3, 0);
    junk(4);
    drv(1'b0, 1'b1, 0, 0, 1'b0, 0, 0, 0);
    junk(3);
    drv(1'b1, 1'b0, 120, 1, 1'b1, 5, 4, 0);
    junk(6);
    #1 rst = 1'b1;
    #1;
    chk("async_rst0", {b0.oEnable, b0.oFreq, b0.oBusy, b0.oDone}, mk(1'b0, 0, 1'b0, 1'b0));
    chk("async_rst1", {b1.oEnable, b1.oFreq, b1.oBusy, b1.oDone}, mk(1'b0, 0, 1'b0, 1'b0));
    junk(2);
    drv(1'b1, 1'b0, 60, 20, 1'b1, 3, 1, 0);
    rst = 1'b0;
    junk(15);
    if (REP_EN) begin
      drv(1'b1, 1'b0, 40, 4, 1'b1, 2, 3, 1);
      junk(40);
      drv(1'b1, 1'b0, 90, 30, 1'b0, 3, 2, 15);
      junk(100);
      drv(1'b0, 1'b1, 0, 0, 1'b0, 0, 0, 0);
      junk(5);
    end
    for (int i = 0; i < 120; i++) begin
      int rp;
      rp = !REP_EN ? 0 : ($urandom_range(0, 9) == 0 ? 15 : $urandom_range(0, 2));
      drv(1'b1, $urandom_range(0, 9) == 0, pick_start(),
          $urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 40),
          1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 4), rp);
      junk($urandom_range(0, 60));
      if (rp == 15 || $urandom_range(0, 4) == 0) drv(1'b0, 1'b1, 0, 0, 1'b0, 0, 0, 0);
    end
    drv(1'b0, 1'b1, 0, 0, 1'b0, 0, 0, 0);
    junk(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
